// File: rtl/demux1_4_reg_if.sv
// Source/sink bundle for the registered 1-to-4 demultiplexer.
// The master drives the word and consumer readies; the slave returns channel state.
interface demux1_4_reg_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in;
    logic [1:0]       sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_1;
    logic [WIDTH-1:0] out_2;
    logic [WIDTH-1:0] out_3;
    logic [WIDTH-1:0] out_4;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;

    modport master (
        output in, sel, in_valid, out_ready,
        input  in_ready, out_1, out_2, out_3, out_4, out_valid
    );

    modport slave (
        input  in, sel, in_valid, out_ready,
        output in_ready, out_1, out_2, out_3, out_4, out_valid
    );
endinterface

// File: rtl/demux1_4_reg.sv
// Registered 1-to-4 demultiplexer: one holding register per channel,
// so a stalled consumer blocks only the source, never the other channels.
module demux1_4_reg #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           reset,
    demux1_4_reg_if.slave bus
);
    logic [WIDTH-1:0] r_data [4];
    logic [3:0]       r_valid;
    logic [3:0]       w_sel_oh;
    logic [3:0]       w_accept;
    logic [3:0]       w_drain;
    logic             w_in_ready;

    // A full channel draining this cycle may accept in the same cycle.
    always_comb begin
        w_sel_oh   = 4'b0001 << bus.sel;
        w_in_ready = !reset &&
                     (!r_valid[bus.sel] || bus.out_ready[bus.sel]);
        w_accept   = (bus.in_valid && w_in_ready) ? w_sel_oh : 4'b0000;
        w_drain    = r_valid & bus.out_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                r_data[k] <= '0;
            end
            r_valid <= 4'b0000;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_accept[k]) begin
                    r_data[k] <= bus.in;
                end
            end
            r_valid <= (r_valid & ~w_drain) | w_accept;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_1     = r_data[0];
    assign bus.out_2     = r_data[1];
    assign bus.out_3     = r_data[2];
    assign bus.out_4     = r_data[3];
    assign bus.out_valid = r_valid;
endmodule

// File: tb/tb_demux1_4_reg.sv
// Directed table-driven bench for demux1_4_reg.
// Each row: inputs for one cycle, expected in_ready and post-edge state.
module tb_demux1_4_reg;
    logic clk = 1'b0;
    logic reset;

    demux1_4_reg_if #(.WIDTH(32)) bus ();

    demux1_4_reg #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] din;
        logic [1:0]  sel;
        logic        iv;
        logic [3:0]  ordy;
        logic        e_ir;
        logic [3:0]  e_v;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] e3;
        logic [31:0] e4;
    } vec_t;

    vec_t tbl [21];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic r, input logic [31:0] d,
                         input logic [1:0] s, input logic v,
                         input logic [3:0] o);
        reset         = r;
        bus.in        = d;
        bus.sel       = s;
        bus.in_valid  = v;
        bus.out_ready = o;
    endtask

    task automatic chk_state(input string tag, input logic [3:0] v,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic [31:0] d);
        chk({tag, " out_valid"}, {28'd0, bus.out_valid}, {28'd0, v});
        chk({tag, " out_1"}, bus.out_1, a);
        chk({tag, " out_2"}, bus.out_2, b);
        chk({tag, " out_3"}, bus.out_3, c);
        chk({tag, " out_4"}, bus.out_4, d);
    endtask

    initial begin
        // rst din sel iv ordy | ir valid out_1..out_4
        tbl[0]  = '{1, 32'hFFFFFFFF, 0, 1, 4'b0000, 0, 4'b0000,
                    32'h0, 32'h0, 32'h0, 32'h0};
        tbl[1]  = '{1, 32'hFFFFFFFF, 0, 1, 4'b0000, 0, 4'b0000,
                    32'h0, 32'h0, 32'h0, 32'h0};
        tbl[2]  = '{0, 32'hA5A50003, 2, 1, 4'b0000, 1, 4'b0100,
                    32'h0, 32'h0, 32'hA5A50003, 32'h0};
        tbl[3]  = '{0, 32'h0, 0, 0, 4'b0100, 1, 4'b0000,
                    32'h0, 32'h0, 32'hA5A50003, 32'h0};
        tbl[4]  = '{0, 32'h11, 0, 1, 4'b0000, 1, 4'b0001,
                    32'h11, 32'h0, 32'hA5A50003, 32'h0};
        tbl[5]  = '{0, 32'h22, 0, 1, 4'b0000, 0, 4'b0001,
                    32'h11, 32'h0, 32'hA5A50003, 32'h0};
        tbl[6]  = '{0, 32'h22, 0, 1, 4'b0001, 1, 4'b0001,
                    32'h22, 32'h0, 32'hA5A50003, 32'h0};
        tbl[7]  = '{0, 32'h33, 1, 1, 4'b0000, 1, 4'b0011,
                    32'h22, 32'h33, 32'hA5A50003, 32'h0};
        tbl[8]  = '{0, 32'h44, 3, 1, 4'b0000, 1, 4'b1011,
                    32'h22, 32'h33, 32'hA5A50003, 32'h44};
        tbl[9]  = '{0, 32'h55, 0, 1, 4'b0000, 0, 4'b1011,
                    32'h22, 32'h33, 32'hA5A50003, 32'h44};
        tbl[10] = '{0, 32'h0, 2, 0, 4'b0100, 1, 4'b1011,
                    32'h22, 32'h33, 32'hA5A50003, 32'h44};
        tbl[11] = '{0, 32'h1, 0, 1, 4'b1111, 1, 4'b0001,
                    32'h1, 32'h33, 32'hA5A50003, 32'h44};
        tbl[12] = '{0, 32'h2, 0, 1, 4'b1111, 1, 4'b0001,
                    32'h2, 32'h33, 32'hA5A50003, 32'h44};
        tbl[13] = '{0, 32'h3, 0, 1, 4'b1111, 1, 4'b0001,
                    32'h3, 32'h33, 32'hA5A50003, 32'h44};
        tbl[14] = '{0, 32'h4, 0, 1, 4'b1111, 1, 4'b0001,
                    32'h4, 32'h33, 32'hA5A50003, 32'h44};
        tbl[15] = '{0, 32'h0, 0, 0, 4'b0000, 0, 4'b0001,
                    32'h4, 32'h33, 32'hA5A50003, 32'h44};
        tbl[16] = '{0, 32'h66, 1, 1, 4'b0000, 1, 4'b0011,
                    32'h4, 32'h66, 32'hA5A50003, 32'h44};
        tbl[17] = '{0, 32'h77, 2, 1, 4'b0000, 1, 4'b0111,
                    32'h4, 32'h66, 32'h77, 32'h44};
        tbl[18] = '{0, 32'h88, 3, 1, 4'b0000, 1, 4'b1111,
                    32'h4, 32'h66, 32'h77, 32'h88};
        tbl[19] = '{1, 32'h99, 0, 1, 4'b0000, 0, 4'b0000,
                    32'h0, 32'h0, 32'h0, 32'h0};
        tbl[20] = '{0, 32'h55, 1, 1, 4'b0000, 1, 4'b0010,
                    32'h0, 32'h55, 32'h0, 32'h0};

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].rst, tbl[i].din, tbl[i].sel,
                  tbl[i].iv, tbl[i].ordy);
            #2;
            chk($sformatf("v%0d in_ready", i),
                {31'd0, bus.in_ready}, {31'd0, tbl[i].e_ir});
            @(posedge clk);
            #1;
            chk_state($sformatf("v%0d", i), tbl[i].e_v,
                      tbl[i].e1, tbl[i].e2, tbl[i].e3, tbl[i].e4);
        end

        // Channel 2 full: in_ready must follow out_ready within the cycle,
        // and changing in while stalled must not reach out_2.
        drive(0, 32'hAA, 1, 1, 4'b0000);
        #2;
        chk("seq stall in_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.in = 32'hBB;
        #1;
        chk("seq stall out_2", bus.out_2, 32'h55);
        bus.out_ready = 4'b0010;
        #1;
        chk("seq release in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk_state("seq pass", 4'b0010, 32'h0, 32'hBB, 32'h0, 32'h0);

        // Drain with no accept: valid drops, data retained.
        drive(0, 32'hCC, 1, 0, 4'b0010);
        @(posedge clk);
        #1;
        chk_state("seq drain", 4'b0000, 32'h0, 32'hBB, 32'h0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/demux1_4_reg.md
Name: demux1_4_reg

Overview:
- Registered 1-to-4 demultiplexer. It is the write-side counterpart of mux4_1: it steers one WIDTH-bit source word to one of four destination channels, selected by sel.
- Each channel has a one-entry holding register with a valid/ready handshake, so a slow consumer stalls only the source, never the other channels.
- Use: fan-out of a single producer (e.g. writeback/result bus) to four consumers in the pipeline.

Parameters:
- WIDTH, 32, data width of in and of out_1..out_4.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  WIDTH  source data word.
- sel  input  2  destination select: 00 -> out_1, 01 -> out_2, 10 -> out_3, 11 -> out_4.
- in_valid  input  1  source offers in/sel this cycle.
- in_ready  output  1  selected channel can accept this cycle (combinational).
- out_1  output  WIDTH  channel 1 holding register.
- out_2  output  WIDTH  channel 2 holding register.
- out_3  output  WIDTH  channel 3 holding register.
- out_4  output  WIDTH  channel 4 holding register.
- out_valid  output  4  bit k-1 set when out_k holds an undelivered word.
- out_ready  input  4  bit k-1: consumer of out_k takes the word this cycle.

Behaviour:
- Reset: clk and reset as named above; reset is synchronous and active-high, sampled on the rising clk edge. While reset=1 at the edge: out_1..out_4 <= 0, out_valid <= 4'b0000. in_ready = 0 combinationally whenever reset=1.
- Channel index: c = sel.
- in_ready = !reset && (!out_valid[c] || out_ready[c]). Pass-through: a full channel that drains in a cycle can accept in that same cycle.
- Accept: occurs when in_valid && in_ready. At the next edge, out_(c+1) <= in and out_valid[c] <= 1. Latency is 1 cycle from accept to out_valid.
- Drain: occurs on channel k when out_valid[k] && out_ready[k]. At the next edge out_valid[k] <= 0, unless the same cycle also accepts into k.
- Simultaneous accept and drain on the same channel: the register takes the new word and out_valid stays 1. No bubble, no loss.
- Accept on one channel with drains on other channels in the same cycle: all are independent and all take effect.
- out_ready[k] while out_valid[k]=0: ignored, no state change.
- Stall: in_valid=1 with in_ready=0 changes no state. The source must hold the word until accept. sel may change between cycles; acceptance is evaluated each cycle against the current sel only.
- Data hold: out_k changes only on accept into k or on reset. After a drain, the last word is retained (not cleared). Consumers qualify with out_valid.
- Data ordering per channel is preserved. Nothing is dropped or duplicated: every accepted word produces exactly one out_valid=1 handshake.
- Reset mid-operation: undelivered words are discarded, all valids clear at that edge, and in_ready is 0 during reset.
- No combinational path from in to any out_k. The only combinational path is out_ready/sel/reset to in_ready.
- Width rules: no arithmetic. in is copied bit-exact.

Test Plan:
- Reset: drive reset=1 for 2 cycles with in_valid=1, in=32'hFFFFFFFF -> in_ready=0, out_valid=4'b0000, out_1..out_4=0 after the edge.
- Basic route: sel=2'b10, in=32'hA5A5_0003, in_valid=1 for one cycle -> next cycle out_3=32'hA5A5_0003, out_valid=4'b0100, other outputs unchanged at 0.
- Backpressure: channel 1 full (out_1=32'h11, out_valid[0]=1), out_ready=0, sel=00, in=32'h22 -> in_ready=0 and out_1 stays 32'h11. Then raise out_ready[0]=1 -> in_ready=1 in the same cycle, next cycle out_1=32'h22 with out_valid[0]=1.
- Isolation: channel 1 stalled full. sel=01, in=32'h33 -> accepted, out_2=32'h33, out_valid=4'b0011. Repeat for sel=11 with in=32'h44 -> out_valid=4'b1011.
- Stream: all out_ready=1, sel=00, in=1,2,3,4 on consecutive cycles -> out_1 shows 1,2,3,4 on consecutive cycles, out_valid[0] stays 1 throughout, in_ready=1 every cycle.
- Reset mid-op: out_valid=4'b1111 with data loaded, assert reset for one cycle -> next cycle out_valid=0, all outputs=0. A subsequent sel=01, in=32'h55 -> out_2=32'h55.
